// File: rtl/game_timer_if.sv
// Control/status bundle between the game FSM and the countdown timer.
interface game_timer_if #(
  parameter int unsigned TIME_W = 7
);
  logic              tick;
  logic              start;
  logic              pause;
  logic              load;
  logic [TIME_W-1:0] load_val;
  logic [TIME_W-1:0] time_out;
  logic              running;
  logic              paused;
  logic              warn;
  logic              done;
  logic              expired;

  modport master (
    output tick, start, pause, load, load_val,
    input  time_out, running, paused, warn, done, expired
  );

  modport slave (
    input  tick, start, pause, load, load_val,
    output time_out, running, paused, warn, done, expired
  );
endinterface

// File: rtl/game_timer_ctrl.sv
// Game countdown timer paced by a 100 ms tick strobe: pause/resume, runtime
// preset load, low-time warning, one-cycle done pulse, optional auto-reload.
module game_timer_ctrl #(
  parameter int unsigned TICKS_PER_UNIT = 10,
  parameter int unsigned TIME_W         = 7,
  parameter int unsigned DEFAULT_TIME   = 30,
  parameter int unsigned WARN_TIME      = 5,
  parameter int unsigned AUTO_RELOAD    = 0
) (
  input  logic        clk,
  input  logic        rst,
  game_timer_if.slave tmr
);

  localparam int unsigned       SUB_W    = (TICKS_PER_UNIT > 1) ? $clog2(TICKS_PER_UNIT) : 1;
  localparam logic [SUB_W-1:0]  SUB_LAST = SUB_W'(TICKS_PER_UNIT - 1);
  localparam logic [TIME_W-1:0] DEF_T    = TIME_W'(DEFAULT_TIME);
  localparam logic [TIME_W-1:0] WARN_T   = TIME_W'(WARN_TIME);
  localparam logic [TIME_W-1:0] ONE_T    = TIME_W'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_PAUSE   = 2'd2,
    S_EXPIRED = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [TIME_W-1:0] preset_q, preset_d;
  logic [TIME_W-1:0] time_q, time_d;
  logic [SUB_W-1:0]  sub_q, sub_d;
  logic              done_q, done_d;
  logic              warn_q, warn_d;
  logic              running_q, paused_q, expired_q;

  always_comb begin
    preset_d = tmr.load ? tmr.load_val : preset_q;
    state_d  = state_q;
    time_d   = time_q;
    sub_d    = sub_q;
    done_d   = 1'b0;

    // start wins in every state and sees a same-cycle load through preset_d
    if (tmr.start) begin
      sub_d = '0;
      if ((preset_d == '0) && (AUTO_RELOAD == 0)) begin
        state_d = S_EXPIRED;
        time_d  = '0;
        done_d  = 1'b1;
      end else begin
        state_d = S_RUN;
        time_d  = preset_d;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (tmr.load) time_d = tmr.load_val;
        end
        S_RUN: begin
          if (tmr.pause) begin
            state_d = S_PAUSE;
          end else if (tmr.tick) begin
            if (sub_q == SUB_LAST) begin
              sub_d = '0;
              if (time_q <= ONE_T) begin
                done_d = 1'b1;
                if (AUTO_RELOAD != 0) begin
                  time_d = preset_q;
                end else begin
                  time_d  = '0;
                  state_d = S_EXPIRED;
                end
              end else begin
                time_d = time_q - ONE_T;
              end
            end else begin
              sub_d = sub_q + 1'b1;
            end
          end
        end
        S_PAUSE: begin
          if (!tmr.pause) state_d = S_RUN;
        end
        S_EXPIRED: begin
          time_d = '0;
        end
        default: begin
          state_d  = S_IDLE;
          time_d   = DEF_T;
          sub_d    = '0;
          preset_d = DEF_T;
        end
      endcase
    end

    warn_d = ((state_d == S_RUN) || (state_d == S_PAUSE)) && (time_d <= WARN_T);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      preset_q  <= DEF_T;
      time_q    <= DEF_T;
      sub_q     <= '0;
      done_q    <= 1'b0;
      warn_q    <= 1'b0;
      running_q <= 1'b0;
      paused_q  <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      preset_q  <= preset_d;
      time_q    <= time_d;
      sub_q     <= sub_d;
      done_q    <= done_d;
      warn_q    <= warn_d;
      running_q <= (state_d == S_RUN);
      paused_q  <= (state_d == S_PAUSE);
      expired_q <= (state_d == S_EXPIRED);
    end
  end

  assign tmr.time_out = time_q;
  assign tmr.running  = running_q;
  assign tmr.paused   = paused_q;
  assign tmr.warn     = warn_q;
  assign tmr.done     = done_q;
  assign tmr.expired  = expired_q;

endmodule

// File: tb/tb_game_timer_ctrl.sv
// Directed bench for game_timer_ctrl: one stop-on-expiry instance and one
// auto-reload instance, inputs driven and outputs sampled on the falling edge.
module tb_game_timer_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   done0;
  int   done1;

  game_timer_if #(.TIME_W(7)) if0 ();
  game_timer_if #(.TIME_W(7)) if1 ();

  game_timer_ctrl #(
    .TICKS_PER_UNIT(10), .TIME_W(7), .DEFAULT_TIME(30), .WARN_TIME(5), .AUTO_RELOAD(0)
  ) u_dut (
    .clk(clk), .rst(rst), .tmr(if0.slave)
  );

  game_timer_ctrl #(
    .TICKS_PER_UNIT(10), .TIME_W(7), .DEFAULT_TIME(30), .WARN_TIME(5), .AUTO_RELOAD(1)
  ) u_ar (
    .clk(clk), .rst(rst), .tmr(if1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // done is high for whole clock cycles, so each falling edge sees each high cycle once
  always @(negedge clk) begin
    if (if0.done === 1'b1) done0 = done0 + 1;
    if (if1.done === 1'b1) done1 = done1 + 1;
  end

  task automatic tick0(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk) if0.tick = 1'b1;
      @(negedge clk) if0.tick = 1'b0;
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic tick1(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk) if1.tick = 1'b1;
      @(negedge clk) if1.tick = 1'b0;
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic start0();
    @(negedge clk) if0.start = 1'b1;
    @(negedge clk) if0.start = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    {if0.tick, if0.start, if0.pause, if0.load} = '0;
    {if1.tick, if1.start, if1.pause, if1.load} = '0;
    if0.load_val = '0;
    if1.load_val = '0;
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (if0.time_out !== 7'd30) begin errors++; $display("FAIL reset_time: got %0d expected 30", if0.time_out); end
    checks++; if (if0.running !== 1'b0) begin errors++; $display("FAIL reset_running: got %0b expected 0", if0.running); end
    checks++; if (if0.paused !== 1'b0) begin errors++; $display("FAIL reset_paused: got %0b expected 0", if0.paused); end
    checks++; if (if0.warn !== 1'b0) begin errors++; $display("FAIL reset_warn: got %0b expected 0", if0.warn); end
    checks++; if (if0.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b expected 0", if0.done); end
    checks++; if (if0.expired !== 1'b0) begin errors++; $display("FAIL reset_expired: got %0b expected 0", if0.expired); end
    checks++; if (if1.time_out !== 7'd30) begin errors++; $display("FAIL reset_ar_time: got %0d expected 30", if1.time_out); end
  endtask

  task automatic test_countdown();
    int d;
    int exp;
    apply_reset();
    d = done0;
    start0();
    checks++; if (if0.running !== 1'b1) begin errors++; $display("FAIL cd_running: got %0b expected 1", if0.running); end
    checks++; if (if0.time_out !== 7'd30) begin errors++; $display("FAIL cd_start_time: got %0d expected 30", if0.time_out); end
    for (int unsigned k = 1; k <= 300; k++) begin
      tick0(1);
      if ((k % 10) == 0) begin
        exp = 30 - int'(k / 10);
        checks++; if (if0.time_out !== 7'(exp)) begin errors++; $display("FAIL cd_time_k%0d: got %0d expected %0d", k, if0.time_out, exp); end
      end
      if (k == 249) begin
        checks++; if (if0.warn !== 1'b0) begin errors++; $display("FAIL cd_warn_t6: got %0b expected 0", if0.warn); end
      end
      if (k == 250) begin
        checks++; if (if0.warn !== 1'b1) begin errors++; $display("FAIL cd_warn_t5: got %0b expected 1", if0.warn); end
      end
    end
    checks++; if (done0 - d !== 1) begin errors++; $display("FAIL cd_done_count: got %0d expected 1", done0 - d); end
    checks++; if (if0.expired !== 1'b1) begin errors++; $display("FAIL cd_expired: got %0b expected 1", if0.expired); end
    checks++; if (if0.running !== 1'b0) begin errors++; $display("FAIL cd_running_end: got %0b expected 0", if0.running); end
    checks++; if (if0.warn !== 1'b0) begin errors++; $display("FAIL cd_warn_end: got %0b expected 0", if0.warn); end
    tick0(15);
    checks++; if (if0.time_out !== 7'd0) begin errors++; $display("FAIL cd_no_underflow: got %0d expected 0", if0.time_out); end
    checks++; if (done0 - d !== 1) begin errors++; $display("FAIL cd_done_after: got %0d expected 1", done0 - d); end
  endtask

  task automatic test_pause_resume();
    apply_reset();
    start0();
    tick0(15);
    checks++; if (if0.time_out !== 7'd29) begin errors++; $display("FAIL pr_time15: got %0d expected 29", if0.time_out); end
    @(negedge clk) if0.pause = 1'b1;
    @(negedge clk);
    checks++; if (if0.paused !== 1'b1) begin errors++; $display("FAIL pr_paused: got %0b expected 1", if0.paused); end
    checks++; if (if0.running !== 1'b0) begin errors++; $display("FAIL pr_not_running: got %0b expected 0", if0.running); end
    tick0(50);
    checks++; if (if0.time_out !== 7'd29) begin errors++; $display("FAIL pr_frozen: got %0d expected 29", if0.time_out); end
    @(negedge clk) if0.pause = 1'b0;
    @(negedge clk);
    checks++; if (if0.running !== 1'b1) begin errors++; $display("FAIL pr_resumed: got %0b expected 1", if0.running); end
    tick0(4);
    checks++; if (if0.time_out !== 7'd29) begin errors++; $display("FAIL pr_sub_held: got %0d expected 29", if0.time_out); end
    tick0(1);
    checks++; if (if0.time_out !== 7'd28) begin errors++; $display("FAIL pr_sub_wrap: got %0d expected 28", if0.time_out); end
  endtask

  task automatic test_load_start();
    int  d;
    logic warn_ok;
    apply_reset();
    d = done0;
    @(negedge clk);
    if0.load_val = 7'd3; if0.load = 1'b1; if0.start = 1'b1;
    @(negedge clk);
    if0.load = 1'b0; if0.start = 1'b0;
    checks++; if (if0.running !== 1'b1) begin errors++; $display("FAIL ls_running: got %0b expected 1", if0.running); end
    checks++; if (if0.time_out !== 7'd3) begin errors++; $display("FAIL ls_time: got %0d expected 3", if0.time_out); end
    checks++; if (if0.done !== 1'b0) begin errors++; $display("FAIL ls_no_done_on_start: got %0b expected 0", if0.done); end
    warn_ok = if0.warn;
    for (int unsigned k = 1; k < 30; k++) begin
      tick0(1);
      if (if0.warn !== 1'b1) warn_ok = 1'b0;
    end
    checks++; if (warn_ok !== 1'b1) begin errors++; $display("FAIL ls_warn_held: got %0b expected 1", warn_ok); end
    tick0(1);
    checks++; if (done0 - d !== 1) begin errors++; $display("FAIL ls_done_count: got %0d expected 1", done0 - d); end
    checks++; if (if0.expired !== 1'b1) begin errors++; $display("FAIL ls_expired: got %0b expected 1", if0.expired); end
    checks++; if (if0.time_out !== 7'd0) begin errors++; $display("FAIL ls_time_end: got %0d expected 0", if0.time_out); end
  endtask

  // preset is 3 from the previous scenario
  task automatic test_same_cycle();
    start0();
    checks++; if (if0.time_out !== 7'd3) begin errors++; $display("FAIL sc_restart: got %0d expected 3", if0.time_out); end
    tick0(1);
    @(negedge clk) begin if0.tick = 1'b1; if0.pause = 1'b1; end
    @(negedge clk) if0.tick = 1'b0;
    checks++; if (if0.paused !== 1'b1) begin errors++; $display("FAIL sc_paused: got %0b expected 1", if0.paused); end
    if0.pause = 1'b0;
    @(negedge clk);
    tick0(8);
    checks++; if (if0.time_out !== 7'd3) begin errors++; $display("FAIL sc_tick_ignored: got %0d expected 3", if0.time_out); end
    tick0(1);
    checks++; if (if0.time_out !== 7'd2) begin errors++; $display("FAIL sc_unit_step: got %0d expected 2", if0.time_out); end
    @(negedge clk) if0.pause = 1'b1;
    @(negedge clk);
    checks++; if (if0.paused !== 1'b1) begin errors++; $display("FAIL sc_paused2: got %0b expected 1", if0.paused); end
    start0();
    checks++; if (if0.running !== 1'b1) begin errors++; $display("FAIL sc_start_over_pause: got %0b expected 1", if0.running); end
    checks++; if (if0.time_out !== 7'd3) begin errors++; $display("FAIL sc_start_time: got %0d expected 3", if0.time_out); end
    @(negedge clk);
    checks++; if (if0.paused !== 1'b1) begin errors++; $display("FAIL sc_repause: got %0b expected 1", if0.paused); end
    if0.pause = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_zero_and_reload();
    int d;
    @(negedge clk) begin if0.load_val = 7'd0; if0.load = 1'b1; end
    @(negedge clk) if0.load = 1'b0;
    checks++; if (if0.time_out !== 7'd3) begin errors++; $display("FAIL zr_load_keeps_time: got %0d expected 3", if0.time_out); end
    d = done0;
    start0();
    checks++; if (if0.expired !== 1'b1) begin errors++; $display("FAIL zr_expired: got %0b expected 1", if0.expired); end
    checks++; if (if0.done !== 1'b1) begin errors++; $display("FAIL zr_done: got %0b expected 1", if0.done); end
    checks++; if (if0.time_out !== 7'd0) begin errors++; $display("FAIL zr_time: got %0d expected 0", if0.time_out); end
    @(negedge clk);
    checks++; if (done0 - d !== 1) begin errors++; $display("FAIL zr_done_once: got %0d expected 1", done0 - d); end

    apply_reset();
    @(negedge clk) begin if1.load_val = 7'd2; if1.load = 1'b1; end
    @(negedge clk) if1.load = 1'b0;
    checks++; if (if1.time_out !== 7'd2) begin errors++; $display("FAIL ar_idle_load: got %0d expected 2", if1.time_out); end
    d = done1;
    @(negedge clk) if1.start = 1'b1;
    @(negedge clk) if1.start = 1'b0;
    tick1(10);
    checks++; if (if1.time_out !== 7'd1) begin errors++; $display("FAIL ar_time10: got %0d expected 1", if1.time_out); end
    tick1(10);
    checks++; if (done1 - d !== 1) begin errors++; $display("FAIL ar_done20: got %0d expected 1", done1 - d); end
    checks++; if (if1.time_out !== 7'd2) begin errors++; $display("FAIL ar_reload20: got %0d expected 2", if1.time_out); end
    checks++; if (if1.running !== 1'b1) begin errors++; $display("FAIL ar_running: got %0b expected 1", if1.running); end
    tick1(20);
    checks++; if (done1 - d !== 2) begin errors++; $display("FAIL ar_done40: got %0d expected 2", done1 - d); end
    checks++; if (if1.time_out !== 7'd2) begin errors++; $display("FAIL ar_reload40: got %0d expected 2", if1.time_out); end
    checks++; if (if1.expired !== 1'b0) begin errors++; $display("FAIL ar_never_expired: got %0b expected 0", if1.expired); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    start0();
    tick0(130);
    checks++; if (if0.time_out !== 7'd17) begin errors++; $display("FAIL rs_time17: got %0d expected 17", if0.time_out); end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (if0.time_out !== 7'd30) begin errors++; $display("FAIL rs_async_time: got %0d expected 30", if0.time_out); end
    checks++; if (if0.running !== 1'b0) begin errors++; $display("FAIL rs_async_running: got %0b expected 0", if0.running); end
    checks++; if (if0.paused !== 1'b0 || if0.warn !== 1'b0 || if0.expired !== 1'b0 || if0.done !== 1'b0) begin
      errors++; $display("FAIL rs_async_flags: got p%0b w%0b e%0b d%0b expected all 0", if0.paused, if0.warn, if0.expired, if0.done);
    end
    #1 rst = 1'b0;
    tick0(20);
    checks++; if (if0.time_out !== 7'd30) begin errors++; $display("FAIL rs_ticks_ignored: got %0d expected 30", if0.time_out); end
    checks++; if (if0.running !== 1'b0) begin errors++; $display("FAIL rs_still_idle: got %0b expected 0", if0.running); end
    start0();
    checks++; if (if0.running !== 1'b1) begin errors++; $display("FAIL rs_restart: got %0b expected 1", if0.running); end
  endtask

  initial begin
    checks = 0; errors = 0; done0 = 0; done1 = 0;
    rst = 1'b1;
    {if0.tick, if0.start, if0.pause, if0.load} = '0;
    {if1.tick, if1.start, if1.pause, if1.load} = '0;
    if0.load_val = '0;
    if1.load_val = '0;
    test_reset();
    test_countdown();
    test_pause_resume();
    test_load_start();
    test_same_cycle();
    test_zero_and_reload();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/game_timer_ctrl.md
Name: game_timer_ctrl

Overview:
Parametrised game countdown timer. Counts a loadable number of time units down to zero, paced by an external 100 ms strobe. Adds pause/resume, runtime load, a low-time warning flag, a one-cycle completion pulse and optional auto-reload. Sits between the game FSM (start/pause/load control) and the score/display logic (consumes time_out, warn, done).

Parameters:
TICKS_PER_UNIT, 10, tick strobes per decremented unit (10 x 100 ms = 1 s); legal 1..255
TIME_W, 7, width of time value
DEFAULT_TIME, 30, value loaded at reset and on start when no load has occurred; must fit in TIME_W
WARN_TIME, 5, warn asserts while running/paused and time_out <= WARN_TIME
AUTO_RELOAD, 0, 1 = on expiry reload the preset and keep running; 0 = stop in EXPIRED

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
tick  in  1  one-cycle 100 ms strobe
start  in  1  one-cycle pulse: load preset into time_out, clear sub-count, enter RUN
pause  in  1  level: while high in RUN/PAUSE, counting is frozen
load  in  1  one-cycle pulse: preset <= load_val
load_val  in  TIME_W  new preset value
time_out  out  TIME_W  remaining time units
running  out  1  high in RUN
paused  out  1  high in PAUSE
warn  out  1  low-time flag
done  out  1  one-cycle pulse on expiry
expired  out  1  level, high in EXPIRED

Behaviour:
- Reset (async, immediate): state=IDLE, preset=DEFAULT_TIME, time_out=DEFAULT_TIME, sub-count=0, running=paused=warn=done=expired=0.
- All outputs registered; state-derived flags change on the same edge as the state.
- Sub-counter width ceil(log2(TICKS_PER_UNIT)), min 1 bit. Counts ticks in RUN only. A tick with sub-count == TICKS_PER_UNIT-1 wraps it to 0 and decrements time_out by 1; otherwise sub-count increments.
- load: preset updates on the next edge in any state. time_out is not changed, except in IDLE, where time_out also takes load_val. If load and start occur in the same cycle, start uses load_val.
- States:
  - IDLE: start -> RUN, time_out=preset, sub-count=0. pause and tick are ignored.
  - RUN:
    - pause=1 -> PAUSE. A tick in the same cycle is ignored.
    - start -> restart: time_out=preset, sub-count=0, stay in RUN.
    - Decrement taking time_out 1->0 -> EXPIRED, done=1 for that cycle.
    - With AUTO_RELOAD=1 the same event instead sets time_out=preset, stays in RUN, and still pulses done. expired never asserts in that mode.
  - PAUSE: time_out and sub-count are held. pause=0 -> RUN, and counting resumes on the next tick with the sub-count preserved. start -> RUN with restart values, and takes priority over pause.
  - EXPIRED: time_out=0, expired=1. start -> RUN with restart values. pause, tick and load do not leave EXPIRED; load updates the preset only.
- Zero preset: start with preset 0 -> EXPIRED on the next edge with done pulse. No underflow. time_out never wraps below 0.
- time_out never decrements outside RUN.
- warn = (state is RUN or PAUSE) and time_out <= WARN_TIME. It is registered, so it updates on the edge where time_out changes.
- done is high for exactly one cycle per expiry. It is never asserted by reset, load or start.
- Unused state encodings recover to IDLE with reset values.
- rst asserted mid-count: immediate return to reset values. Counting restarts only on a later start.

Test Plan:
1. Reset, then start with defaults. Apply 300 ticks each 4 cycles apart -> time_out steps 30->0, one step per 10 ticks. warn rises when time_out becomes 5. At tick 300: done pulses once, expired=1, running=0.
2. Pause and resume with sub-count preserved. Start, 15 ticks (time_out=29, sub=5), pause=1, 50 ticks -> time_out stays 29, paused=1. Then pause=0, 5 ticks -> time_out=28.
3. load/start priority. load_val=3 with load and start in the same cycle -> RUN with time_out=3. After 30 ticks -> done pulse, warn was high throughout.
4. Same-cycle events. Tick coincident with pause rising: no count, state PAUSE. start while PAUSE with pause still high -> RUN with time_out=preset.
5. Zero preset and auto-reload. load_val=0, then start -> EXPIRED next edge with done pulse, time_out=0. AUTO_RELOAD=1 instance with preset 2, 20 ticks -> done pulses at ticks 20 and 40, time_out reloads to 2, expired stays 0.
6. Asynchronous reset mid-operation. rst pulsed between clock edges at time_out=17 -> all outputs return to reset values before the next edge; ticks ignored until start.
